pe_requant_drain: RTL and testbench

PE_REQUANT_DRAIN -- requirements
Module: pe_requant_drain

---
 rtl/pe_pkg.sv | 18 +
 rtl/requant_lane.sv | 37 +++
 rtl/pe_requant_drain.sv | 97 +++++++++
 tb/tb_pe_requant_drain.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE result drain path.
package pe_pkg;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

  function automatic longint out_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam int     OUT_WIDTH_DEF = 8;
  localparam longint OUT_MAX       = out_max(OUT_WIDTH_DEF);
  localparam longint OUT_MIN       = out_min(OUT_WIDTH_DEF);

endpackage

// File: rtl/requant_lane.sv
// One lane of bias add, round-half-up right shift and saturation to OUT_W.
module requant_lane
  import pe_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  data,
  input  logic signed [IN_W-1:0]  bias,
  input  logic        [4:0]       shift,
  output logic        [OUT_W-1:0] res,
  output logic                    sat
);
  // Two guard bits: one for the bias add, one for the rounding increment.
  localparam int     EW   = IN_W + 2;
  localparam longint MAXV = out_max(OUT_W);
  localparam longint MINV = out_min(OUT_W);

  logic signed [EW-1:0] s, rnd, r;

  always_comb begin
    s   = {{2{data[IN_W-1]}}, data} + {{2{bias[IN_W-1]}}, bias};
    rnd = '0;
    if (shift != 5'd0) rnd = {{(EW-1){1'b0}}, 1'b1} << (shift - 5'd1);
    r   = (s + rnd) >>> shift;
    sat = 1'b0;
    res = r[OUT_W-1:0];
    if (longint'(r) > MAXV) begin
      sat = 1'b1;
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (longint'(r) < MINV) begin
      sat = 1'b1;
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/pe_requant_drain.sv
// Captures one accumulator vector and drains it as requantized beats.
module pe_requant_drain
  import pe_pkg::*;
#(
  parameter int SUBARRAY_ROWS  = 32,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int LANES_PER_BEAT = 8,
  parameter int OUT_WIDTH      = 8,
  localparam int BEATS = SUBARRAY_ROWS / LANES_PER_BEAT,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [SUBARRAY_ROWS-1:0][OUTPUT_WIDTH-1:0]     in_data,
  input  logic [SUBARRAY_ROWS-1:0][OUTPUT_WIDTH-1:0]     in_bias,
  input  logic [4:0]                                     in_shift,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [LANES_PER_BEAT-1:0][OUT_WIDTH-1:0]       out_data,
  output logic [BW-1:0]                                  out_beat,
  output logic                                           out_last,
  output logic                                           busy,
  output logic [15:0]                                    sat_count,
  input  logic                                           sat_clear,
  output logic                                           drop_err
);

  drain_state_t state;
  logic [BW-1:0] beat;
  logic [BEATS-1:0][LANES_PER_BEAT-1:0][OUTPUT_WIDTH-1:0] data_q, bias_q;
  logic [4:0] shift_q;
  logic [LANES_PER_BEAT-1:0] sat;
  logic [16:0] nsat, sat_sum;
  logic last, xfer;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == DRAIN);
  assign out_valid = busy;
  assign out_beat  = beat;
  assign last      = (beat == BW'(BEATS - 1));
  assign out_last  = out_valid && last;
  assign xfer      = out_valid && out_ready;

  // Operand registers only load on an accepted vector; they need no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_q  <= in_data;
      bias_q  <= in_bias;
      shift_q <= in_shift;
    end
  end

  for (genvar i = 0; i < LANES_PER_BEAT; i++) begin : g_lane
    requant_lane #(.IN_W(OUTPUT_WIDTH), .OUT_W(OUT_WIDTH)) u_lane (
      .data  (data_q[beat][i]),
      .bias  (bias_q[beat][i]),
      .shift (shift_q),
      .res   (out_data[i]),
      .sat   (sat[i])
    );
  end

  always_comb begin
    nsat = '0;
    for (int i = 0; i < LANES_PER_BEAT; i++) nsat = nsat + 17'(sat[i]);
    sat_sum = {1'b0, sat_count} + nsat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      sat_count <= '0;
      drop_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= DRAIN;
          beat  <= '0;
        end
        DRAIN: begin
          if (in_valid) drop_err <= 1'b1;
          if (xfer) begin
            beat <= last ? '0 : beat + 1'b1;
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (sat_clear)  sat_count <= '0;
      else if (xfer)  sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule

// File: tb/tb_pe_requant_drain.sv
// Randomized and directed checks of pe_requant_drain against a plain-arithmetic model.
module tb_pe_requant_drain;
  localparam int ROWS = 32, W = 32, LPB = 8, OW = 8, BEATS = ROWS / LPB;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_last, busy, sat_clear = 0, drop_err;
  logic [ROWS-1:0][W-1:0] in_data = '0, in_bias = '0;
  logic [4:0] in_shift = '0;
  logic [LPB-1:0][OW-1:0] out_data;
  logic [1:0] out_beat;
  logic [15:0] sat_count;

  int checks = 0, errors = 0;
  int sat_exp = 0;
  logic signed [W-1:0] vd[ROWS], vb[ROWS];

  pe_requant_drain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bias(in_bias), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_last(out_last), .busy(busy),
    .sat_count(sat_count), .sat_clear(sat_clear), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic void ref_lane(input longint d, input longint b, input int sh,
                                   output logic [OW-1:0] r, output bit sat);
    longint s, q;
    s = d + b;
    q = (sh == 0) ? s : ((s + (longint'(1) << (sh - 1))) >>> sh);
    sat = (q > 127) || (q < -128);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    r = q[OW-1:0];
  endfunction

  // Loads vd/vb, drains the vector and compares every beat with the model.
  task automatic run_vector(input int sh, input int stall_beat, input int stall_n,
                            input int drop_beat, input int clr_beat);
    logic [OW-1:0] ex[ROWS];
    bit sx[ROWS];
    logic [LPB-1:0][OW-1:0] eb;
    int cyc, bs, exp_cyc;
    for (int i = 0; i < ROWS; i++) ref_lane(longint'(vd[i]), longint'(vb[i]), sh, ex[i], sx[i]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < ROWS; i++) begin in_data[i] = vd[i]; in_bias[i] = vb[i]; end
    in_shift = sh[4:0];
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    cyc = 0;
    for (int b = 0; b < BEATS; b++) begin
      bs = 0;
      for (int i = 0; i < LPB; i++) begin eb[i] = ex[b*LPB+i]; bs += int'(sx[b*LPB+i]); end
      if (b == stall_beat) begin
        out_ready = 0;
        repeat (stall_n) begin
          checks++;
          if (out_beat !== 2'(b) || out_data !== eb || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold beat %0d got %0d/%h want %0d/%h", b, out_beat, out_data, b, eb);
          end
          @(negedge clk); cyc++;
        end
        out_ready = 1;
      end
      if (b == drop_beat) begin
        in_valid = 1;
        for (int i = 0; i < ROWS; i++) in_data[i] = $urandom;
      end
      if (b == clr_beat) sat_clear = 1;
      checks++;
      if (out_valid !== 1'b1 || out_beat !== 2'(b) || out_last !== (b == BEATS - 1) || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL beat_ctl beat %0d got v%b b%0d l%b r%b", b, out_valid, out_beat, out_last, in_ready);
      end
      checks++;
      if (out_data !== eb) begin errors++; $display("FAIL beat_data beat %0d got %h want %h", b, out_data, eb); end
      if (b == clr_beat) sat_exp = 0;
      else sat_exp = (sat_exp + bs > 65535) ? 65535 : sat_exp + bs;
      @(negedge clk); cyc++;
      in_valid = 0; sat_clear = 0;
    end
    exp_cyc = BEATS + ((stall_beat >= 0) ? stall_n : 0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL vec_done got r%b v%b busy%b want 1 0 0", in_ready, out_valid, busy);
    end
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL vec_cycles got %0d want %0d", cyc, exp_cyc); end
    checks++; if (sat_count !== 16'(sat_exp)) begin errors++; $display("FAIL sat_count got %0d want %0d", sat_count, sat_exp); end
    if (drop_beat >= 0) begin
      checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_err got %b want 1", drop_err); end
    end
  endtask

  task automatic fill(input int d, input int b);
    for (int i = 0; i < ROWS; i++) begin vd[i] = d; vb[i] = b; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        out_beat !== 2'd0 || sat_count !== 16'd0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL reset_state got v%b l%b busy%b r%b beat%0d sat%0d drop%b",
                         out_valid, out_last, busy, in_ready, out_beat, sat_count, drop_err);
    end
    rst = 0;
    sat_exp = 0;
  endtask

  task automatic test_basic;
    fill(1000, 0);
    run_vector(3, -1, 0, -1, -1);
  endtask

  task automatic test_saturation;
    fill(-1000, 0);
    run_vector(0, -1, 0, -1, -1);
    sat_clear = 1;
    @(negedge clk); sat_clear = 0;
    sat_exp = 0;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", sat_count); end
    run_vector(0, -1, 0, -1, 3);
  endtask

  task automatic test_rounding;
    fill(0, 0);
    vd[0] = 5; vd[1] = -5;
    run_vector(1, -1, 0, -1, -1);
    fill(99, 28);
    run_vector(0, -1, 0, -1, -1);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < ROWS; i++) begin vd[i] = int'($urandom_range(0, 4000)) - 2000; vb[i] = 7; end
    run_vector(2, 1, 3, -1, -1);
  endtask

  task automatic test_drop;
    for (int i = 0; i < ROWS; i++) begin vd[i] = int'($urandom_range(0, 4000)) - 2000; vb[i] = -3; end
    run_vector(4, -1, 0, 2, -1);
  endtask

  task automatic test_reset_mid;
    fill(-5000, 0);
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) begin in_data[i] = vd[i]; in_bias[i] = vb[i]; end
    in_shift = 0; in_valid = 1;
    @(negedge clk); in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_count !== 16'd0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid got v%b r%b sat%0d drop%b", out_valid, in_ready, sat_count, drop_err);
    end
    @(negedge clk); rst = 0; sat_exp = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_beats got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < ROWS; i++) begin
        vd[i] = (k >= 6) ? $urandom : int'($urandom_range(0, 8000)) - 4000;
        vb[i] = (k >= 6) ? $urandom : int'($urandom_range(0, 2000)) - 1000;
      end
      run_vector(int'($urandom_range(0, (k >= 6) ? 31 : 12)), int'($urandom_range(0, 4)) - 1,
                 int'($urandom_range(1, 3)), -1, -1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_rounding;
    test_backpressure;
    test_drop;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
